// File: rtl/adc_pkg.sv
// Shared encodings for the multi-slope ADC sequencer: FSM states and integrator mux codes.
package adc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RESET,
        RUNUP,
        RUNDOWN,
        DONE
    } adc_state_t;

    // mux bit order is {sig, ref_n, ref_p}
    localparam logic [2:0] MUX_OFF   = 3'b000;
    localparam logic [2:0] MUX_SIG_P = 3'b101;
    localparam logic [2:0] MUX_SIG_N = 3'b110;
    localparam logic [2:0] MUX_REF_P = 3'b001;
    localparam logic [2:0] MUX_REF_N = 3'b010;

    // A high comparator means the integrator needs the negative reference next.
    function automatic logic [2:0] next_phase_mux(input logic cmp, input logic last);
        if (last)
            return cmp ? MUX_REF_N : MUX_REF_P;
        return cmp ? MUX_SIG_N : MUX_SIG_P;
    endfunction

endpackage

// File: rtl/adc_multislope_if.sv
// Register-bank side of the ADC sequencer: run-time configuration in, result snapshot out.
interface adc_multislope_if #(
    parameter int CNT_W = 24,
    parameter int CLK_W = 16
);
    logic             cfg_run;
    logic [CLK_W-1:0] cfg_reset_clks;
    logic [CLK_W-1:0] cfg_phase_clks;
    logic [CNT_W-1:0] cfg_n_phases;
    logic [CNT_W-1:0] cfg_rundown_max;

    logic [CNT_W-1:0] res_up;
    logic [CNT_W-1:0] res_down;
    logic [CNT_W-1:0] res_rundown;
    logic             res_timeout;
    logic [7:0]       res_seq;
    logic             com_interrupt_n;
    logic             busy;

    modport master (
        output cfg_run, cfg_reset_clks, cfg_phase_clks, cfg_n_phases, cfg_rundown_max,
        input  res_up, res_down, res_rundown, res_timeout, res_seq, com_interrupt_n, busy
    );

    modport slave (
        input  cfg_run, cfg_reset_clks, cfg_phase_clks, cfg_n_phases, cfg_rundown_max,
        output res_up, res_down, res_rundown, res_timeout, res_seq, com_interrupt_n, busy
    );
endinterface

// File: rtl/cmpr_sync.sv
// Two-flop synchroniser for the asynchronous comparator, plus a one-cycle edge flag.
module cmpr_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic cmpr_in,
    output logic cmp_s,
    output logic cmp_edge
);
    logic cmp_meta;
    logic cmp_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_meta <= 1'b0;
            cmp_s    <= 1'b0;
            cmp_d    <= 1'b0;
        end else begin
            cmp_meta <= cmpr_in;
            cmp_s    <= cmp_meta;
            cmp_d    <= cmp_s;
        end
    end

    assign cmp_edge = cmp_s ^ cmp_d;

endmodule

// File: rtl/adc_multislope.sv
// Multi-slope run-up/run-down integrating ADC sequencer with per-conversion config shadowing
// and an atomic result snapshot.
//
// state   | meaning
// IDLE    | integrator shorted, waiting for cfg_run; shadows config on start
// RESET   | integrator shorted for the reset-clock count
// RUNUP   | fixed-length phases, reference chosen from the comparator at each phase end
// RUNDOWN | reference only, counting clocks until a comparator edge or timeout
// DONE    | one clock: publish results and start the interrupt pulse
module adc_multislope
    import adc_pkg::*;
#(
    parameter int CNT_W    = 24,
    parameter int CLK_W    = 16,
    parameter int INT_HOLD = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmpr_in,
    adc_multislope_if.slave bus,
    output logic [2:0]  mux,
    output logic        int_short,
    output logic        cmpr_latch
);
    localparam int HOLD_W = $clog2(INT_HOLD + 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    // Timers count down to zero, so a length of 0 behaves like a length of 1.
    function automatic logic [CLK_W-1:0] clk_m1(input logic [CLK_W-1:0] v);
        return (v == '0) ? '0 : v - CLK_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] cnt_m1(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : v - CNT_W'(1);
    endfunction

    adc_state_t       state, state_nxt;
    logic [2:0]       mux_nxt;
    logic             short_nxt, latch_nxt;
    logic             cmp_s, cmp_edge;
    logic [CLK_W-1:0] timer, phase_sh;
    logic [CNT_W-1:0] phase_left, max_sh;
    logic [CNT_W-1:0] up_cnt, dn_cnt, rd_cnt, rd_next;
    logic             timeout;
    logic [HOLD_W-1:0] int_cnt;
    logic             timer_done, last_phase, rd_hit_max;

    cmpr_sync u_cmpr_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmpr_in  (cmpr_in),
        .cmp_s    (cmp_s),
        .cmp_edge (cmp_edge)
    );

    assign timer_done = (timer == '0);
    assign last_phase = (phase_left == '0);
    assign rd_next    = sat_inc(rd_cnt);
    assign rd_hit_max = (rd_next == max_sh);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            mux        <= MUX_OFF;
            int_short  <= 1'b1;
            cmpr_latch <= 1'b1;
        end else begin
            state      <= state_nxt;
            mux        <= mux_nxt;
            int_short  <= short_nxt;
            cmpr_latch <= latch_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mux_nxt   = mux;
        short_nxt = int_short;
        latch_nxt = cmpr_latch;
        case (state)
            IDLE: begin
                short_nxt = 1'b1;
                latch_nxt = 1'b1;
                mux_nxt   = MUX_OFF;
                if (bus.cfg_run)
                    state_nxt = RESET;
            end
            RESET: begin
                if (timer_done) begin
                    state_nxt = RUNUP;
                    short_nxt = 1'b0;
                    latch_nxt = 1'b0;
                    mux_nxt   = MUX_SIG_P;
                end
            end
            RUNUP: begin
                if (timer_done) begin
                    mux_nxt = next_phase_mux(cmp_s, last_phase);
                    if (last_phase)
                        state_nxt = RUNDOWN;
                end
            end
            RUNDOWN: begin
                if (cmp_edge || rd_hit_max) begin
                    state_nxt = DONE;
                    mux_nxt   = MUX_OFF;
                    latch_nxt = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                short_nxt = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer      <= '0;
            phase_sh   <= '0;
            phase_left <= '0;
            max_sh     <= '0;
            up_cnt     <= '0;
            dn_cnt     <= '0;
            rd_cnt     <= '0;
            timeout    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cfg_run) begin
                        timer      <= clk_m1(bus.cfg_reset_clks);
                        phase_sh   <= bus.cfg_phase_clks;
                        phase_left <= cnt_m1(bus.cfg_n_phases);
                        // a zero timeout would never match the saturating count
                        max_sh     <= (bus.cfg_rundown_max == '0) ? CNT_W'(1) : bus.cfg_rundown_max;
                        up_cnt     <= '0;
                        dn_cnt     <= '0;
                        rd_cnt     <= '0;
                        timeout    <= 1'b0;
                    end
                end
                RESET: timer <= timer_done ? clk_m1(phase_sh) : timer - CLK_W'(1);
                RUNUP: begin
                    if (timer_done) begin
                        if (cmp_s)
                            up_cnt <= sat_inc(up_cnt);
                        else
                            dn_cnt <= sat_inc(dn_cnt);
                        if (!last_phase) begin
                            phase_left <= phase_left - CNT_W'(1);
                            timer      <= clk_m1(phase_sh);
                        end
                    end else begin
                        timer <= timer - CLK_W'(1);
                    end
                end
                RUNDOWN: begin
                    rd_cnt <= rd_next;
                    if (!cmp_edge && rd_hit_max)
                        timeout <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Results and interrupt are decoupled from the FSM once DONE has passed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.res_up      <= '0;
            bus.res_down    <= '0;
            bus.res_rundown <= '0;
            bus.res_timeout <= 1'b0;
            bus.res_seq     <= '0;
            int_cnt         <= '0;
        end else if (state == DONE) begin
            bus.res_up      <= up_cnt;
            bus.res_down    <= dn_cnt;
            bus.res_rundown <= rd_cnt;
            bus.res_timeout <= timeout;
            bus.res_seq     <= bus.res_seq + 8'd1;
            int_cnt         <= HOLD_W'(INT_HOLD);
        end else if (int_cnt != '0) begin
            int_cnt <= int_cnt - HOLD_W'(1);
        end
    end

    assign bus.com_interrupt_n = (int_cnt == '0);
    assign bus.busy            = (state != IDLE);

endmodule

// File: doc/adc_multislope.md
# adc_multislope

Parametrised multi-slope run-up/run-down integrating-ADC sequencer. Drives the integrator input mux and comparator latch, counts run-up phases by direction and run-down clocks, then publishes an atomic result snapshot with an active-low interrupt. Run-time configuration comes from the SPI register bank and is latched per conversion. Sits between the register bank and the analog front-end pins in the top level, replacing the hard-coded sequencer.

## Interface
- `CNT_W`, 24: width of the phase counters, run-down counter and result registers.
- `CLK_W`, 16: width of the per-phase and reset clock counts.
- `INT_HOLD`, 8: clocks `com_interrupt_n` is held low per result.
- `clk` in 1: system clock; all logic on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmpr_in` in 1: raw comparator output, asynchronous to `clk`.
- `cfg_run` in 1: enable continuous conversions.
- `cfg_reset_clks` in CLK_W: integrator short duration; 0 is treated as 1.
- `cfg_phase_clks` in CLK_W: clocks per run-up phase; 0 is treated as 1.
- `cfg_n_phases` in CNT_W: run-up phases per conversion; 0 is treated as 1.
- `cfg_rundown_max` in CNT_W: run-down timeout in clocks.
- `mux` out 3: {sig, ref_n, ref_p}; 3'b000 means all off.
- `int_short` out 1: high shorts the integrator.
- `cmpr_latch` out 1: comparator latch; 0 means transparent.
- `res_up`, `res_down`, `res_rundown` out CNT_W: last result.
- `res_timeout` out 1: last run-down hit `cfg_rundown_max`.
- `res_seq` out 8: increments on each published result.
- `com_interrupt_n` out 1: active-low result interrupt.
- `busy` out 1: high in any state other than IDLE.

## Operation
- Reset values: `mux`=000, `int_short`=1, `cmpr_latch`=1, all `res_*`=0, `com_interrupt_n`=1, `busy`=0, state=IDLE.
- `cmpr_in` passes through a 2-flop synchroniser. `cmp_s` is the second flop. An edge is `cmp_s` differing from its 1-cycle delayed copy.
- IDLE: `int_short`=1, `mux`=000. If `cfg_run`, latch all `cfg_*` into shadow registers, clear counters, go to RESET. A cfg change mid-conversion has no effect until the next IDLE.
- RESET: `int_short`=1 for the shadow reset-clock count. Then set `int_short`=0, `cmpr_latch`=0, `mux`=101 (sig + ref_p), and go to RUNUP.
- RUNUP: the phase clock counter runs. On its last clock:
  - Sample `cmp_s`. If 1, the next phase `mux`=110 and `res_up`-side counter +1. If 0, the next phase `mux`=101 and down counter +1.
  - After the shadow phase count is reached, go to RUNDOWN instead.
  - The ref direction for RUNDOWN comes from that final sample, with the sig bit cleared: 010 if 1, 001 if 0.
- RUNDOWN: the run-down counter increments every clock. Exit on the first synchronised edge, or when the count equals the shadow timeout (which sets the timeout flag). On exit: `mux`=000, `cmpr_latch`=1, go to DONE.
- DONE (1 clock):
  - Copy up, down, run-down and timeout into `res_*` in the same clock; `res_seq`+1 (wraps at 255).
  - Assert `com_interrupt_n`=0 for INT_HOLD clocks, independent of the state machine.
  - Go to IDLE.
- `cfg_run` deasserted mid-conversion: the current conversion completes and publishes, then the block stays in IDLE.
- Counters saturate at all-ones and never wrap.
- `rst_n` low mid-conversion: immediately return to reset values; partial counts are discarded.

## Timing
- Comparator edge to RUNDOWN exit: 3 clocks (2 sync + 1 detect). The run-down count includes these clocks.
- Run-up phase length is exactly the shadow phase-clock count. Phase boundaries never slip.
- Result registers are stable except in the single DONE clock. `com_interrupt_n` falls in the clock after DONE, with results already valid.
- IDLE to RESET takes 1 clock. The minimum conversion is reset + n×phase + rundown + 2 clocks.

## Structure
- Shared package `adc_pkg`:
  - State encoding: IDLE, RESET, RUNUP, RUNDOWN, DONE.
  - Mux constants: `MUX_OFF`=000, `MUX_SIG_P`=101, `MUX_SIG_N`=110, `MUX_REF_P`=001, `MUX_REF_N`=010.
- Sub-module `cmpr_sync`: 2-flop synchroniser plus edge detector, async active-low reset, outputs `cmp_s` and `cmp_edge`.

## Test plan
- reset_clks=5, phase_clks=10, n_phases=4, comparator model toggling each phase: `res_up`=2, `res_down`=2, one interrupt pulse of 8 clocks, `res_seq`=1.
- Comparator held high for all phases, then an edge 37 clocks into rundown: `res_up`=4, `res_down`=0, `res_rundown`=40, rundown `mux`=010.
- No comparator edge, rundown_max=100: exit at 100, `res_timeout`=1, `mux`=000.
- Change `cfg_phase_clks` 10→20 mid-RUNUP: the current conversion keeps 10-clock phases and the next uses 20.
- Pulse `rst_n` low during RUNUP: all outputs return to reset values asynchronously, with no interrupt.
- `cfg_run` dropped in RUNUP: that result still publishes, then `busy`=0 and the block stays in IDLE.
